// File: rtl/paper_machine.sv
// paper_machine: counter-machine instruction sequencer (INC/DEC/JMP/ISZ/CLR/HALT)
// over NREG registers of REG_W bits, fetching from an external combinational
// instruction memory. Every instruction takes two enabled cycles: FETCH, then EXEC.
// A debug port preloads and reads registers while the core is in IDLE or HALT.
// Optional feature macro: PAPER_STEP_EN adds the `step` input, which gates FETCH->EXEC.
module paper_machine #(
  parameter  int PC_W  = 4,
  parameter  int NREG  = 4,
  parameter  int REG_W = 8,
  localparam int SEL_W = (NREG > 1) ? $clog2(NREG) : 1,
  localparam int IW    = PC_W + 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clk_en,
`ifdef PAPER_STEP_EN
  input  logic             step,
`endif
  input  logic             start,
  output logic [PC_W-1:0]  instr_addr,
  input  logic [IW-1:0]    instr_data,
  output logic [1:0]       state,
  output logic             halted,
  output logic             fault,
  input  logic [SEL_W-1:0] dbg_sel,
  input  logic             dbg_we,
  input  logic [REG_W-1:0] dbg_wdata,
  output logic [REG_W-1:0] dbg_rdata
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_FETCH = 2'b01,
    ST_EXEC  = 2'b10,
    ST_HALT  = 2'b11
  } state_e;

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_INC  = 3'b001;
  localparam logic [2:0] OP_DEC  = 3'b010;
  localparam logic [2:0] OP_JMP  = 3'b011;
  localparam logic [2:0] OP_ISZ  = 3'b100;
  localparam logic [2:0] OP_CLR  = 3'b101;
  localparam logic [2:0] OP_RSV  = 3'b110;
  localparam logic [2:0] OP_HALT = 3'b111;

  state_e           state_q;
  logic [PC_W-1:0]  pc_q;
  logic [IW-1:0]    ir_q;
  logic             fault_q;
  logic             halted_q;
  logic [REG_W-1:0] regs_q [NREG];

  // Decoded view of the latched instruction.
  logic [2:0]       opcode_s;
  logic [PC_W-1:0]  operand_s;
  logic [SEL_W-1:0] reg_idx_s;
  logic             reg_ok_s;
  logic [REG_W-1:0] reg_val_s;
  logic             advance_s;

  // EXEC results, committed by the FSM on the EXEC edge.
  logic [PC_W-1:0]  pc_d;
  logic             wr_en_d;
  logic [REG_W-1:0] wr_data_d;
  logic             fault_set_d;
  logic             halt_d;

  assign opcode_s  = ir_q[IW-1:PC_W];
  assign operand_s = ir_q[PC_W-1:0];
  // Out-of-range operands only use their low bits for the register lookup;
  // reg_ok_s turns such instructions into a faulting NOP.
  assign reg_idx_s = operand_s[SEL_W-1:0];
  assign reg_ok_s  = (int'(operand_s) < NREG);
  assign reg_val_s = regs_q[reg_idx_s];

`ifdef PAPER_STEP_EN
  assign advance_s = step;
`else
  assign advance_s = 1'b1;
`endif

  // Execute stage: compute next pc, register write-back and fault/halt requests.
  always_comb begin
    pc_d        = pc_q + PC_W'(1);
    wr_en_d     = 1'b0;
    wr_data_d   = reg_val_s;
    fault_set_d = 1'b0;
    halt_d      = 1'b0;
    case (opcode_s)
      OP_NOP: begin
        pc_d = pc_q + PC_W'(1);
      end
      OP_INC: begin
        if (reg_ok_s) begin
          wr_en_d   = 1'b1;
          wr_data_d = reg_val_s + REG_W'(1);
        end else begin
          fault_set_d = 1'b1;
        end
      end
      OP_DEC: begin
        if (!reg_ok_s) begin
          fault_set_d = 1'b1;
        end else if (reg_val_s == REG_W'(0)) begin
          // Underflow: the register stays at zero and the fault is flagged.
          fault_set_d = 1'b1;
        end else begin
          wr_en_d   = 1'b1;
          wr_data_d = reg_val_s - REG_W'(1);
        end
      end
      OP_JMP: begin
        pc_d = operand_s;
      end
      OP_ISZ: begin
        if (!reg_ok_s) begin
          fault_set_d = 1'b1;
        end else if (reg_val_s == REG_W'(0)) begin
          pc_d = pc_q + PC_W'(2);
        end else begin
          pc_d = pc_q + PC_W'(1);
        end
      end
      OP_CLR: begin
        if (reg_ok_s) begin
          wr_en_d   = 1'b1;
          wr_data_d = REG_W'(0);
        end else begin
          fault_set_d = 1'b1;
        end
      end
      OP_RSV: begin
        fault_set_d = 1'b1;
      end
      OP_HALT: begin
        // pc stays on the HALT word so the host can see where the program stopped.
        pc_d   = pc_q;
        halt_d = 1'b1;
      end
      default: begin
        pc_d = pc_q + PC_W'(1);
      end
    endcase
  end

  // Sequencer FSM with register file, debug writes and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      pc_q     <= '0;
      ir_q     <= '0;
      fault_q  <= 1'b0;
      halted_q <= 1'b0;
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else if (clk_en) begin
      case (state_q)
        ST_IDLE, ST_HALT: begin
          if (dbg_we) begin
            regs_q[dbg_sel] <= dbg_wdata;
          end
          if (start) begin
            state_q  <= ST_FETCH;
            pc_q     <= '0;
            fault_q  <= 1'b0;
            halted_q <= 1'b0;
          end
        end
        ST_FETCH: begin
          if (advance_s) begin
            ir_q    <= instr_data;
            state_q <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          pc_q <= pc_d;
          if (wr_en_d) begin
            regs_q[reg_idx_s] <= wr_data_d;
          end
          if (fault_set_d) begin
            fault_q <= 1'b1;
          end
          if (halt_d) begin
            state_q  <= ST_HALT;
            halted_q <= 1'b1;
          end else begin
            state_q  <= ST_FETCH;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign instr_addr = pc_q;
  assign state      = state_q;
  assign halted     = halted_q;
  assign fault      = fault_q;
  assign dbg_rdata  = regs_q[dbg_sel];

endmodule

// File: tb/tb_paper_machine.sv
// Directed bench for paper_machine: a table of single-instruction vectors plus
// hand-written program sequences for the multi-cycle corner cases.
module tb_paper_machine;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clk_en = 1'b1;
  logic       step = 1'b1;
  logic       start = 1'b0;
  logic [3:0] instr_addr;
  logic [6:0] instr_data;
  logic [1:0] state;
  logic       halted;
  logic       fault;
  logic [1:0] dbg_sel = 2'd0;
  logic       dbg_we = 1'b0;
  logic [7:0] dbg_wdata = 8'd0;
  logic [7:0] dbg_rdata;

  logic [6:0] mem [16];
  assign instr_data = mem[instr_addr];

  int n_checks = 0;
  int n_fail = 0;

  paper_machine dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clk_en     (clk_en),
`ifdef PAPER_STEP_EN
    .step       (step),
`endif
    .start      (start),
    .instr_addr (instr_addr),
    .instr_data (instr_data),
    .state      (state),
    .halted     (halted),
    .fault      (fault),
    .dbg_sel    (dbg_sel),
    .dbg_we     (dbg_we),
    .dbg_wdata  (dbg_wdata),
    .dbg_rdata  (dbg_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] op;
    logic [3:0] arg;
    logic [1:0] sel;
    logic [7:0] pre;
    logic [7:0] exp_reg;
    logic [3:0] exp_pc;
    logic       exp_fault;
  } vec_t;

  vec_t vecs [12];

  function automatic logic [6:0] ins(input logic [2:0] op, input logic [3:0] a);
    return {op, a};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic fill_halt();
    for (int i = 0; i < 16; i++) mem[i] = ins(3'b111, 4'd0);
  endtask

  task automatic read_reg(input logic [1:0] r, output logic [7:0] v);
    dbg_sel = r;
    #1;
    v = dbg_rdata;
  endtask

  task automatic dbg_write(input logic [1:0] r, input logic [7:0] v);
    dbg_sel = r; dbg_wdata = v; dbg_we = 1'b1;
    tick();
    dbg_we = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic run_to_halt(input string name, input int budget);
    for (int i = 0; i < budget && !halted; i++) tick();
    check(name, 32'(halted), 32'd1);
  endtask

  initial begin
    logic [7:0] rv;

    vecs[0]  = '{3'b001, 4'd0, 2'd0, 8'h05, 8'h06, 4'd1, 1'b0}; // INC
    vecs[1]  = '{3'b001, 4'd0, 2'd0, 8'hFF, 8'h00, 4'd1, 1'b0}; // INC wrap
    vecs[2]  = '{3'b010, 4'd1, 2'd1, 8'h03, 8'h02, 4'd1, 1'b0}; // DEC
    vecs[3]  = '{3'b010, 4'd2, 2'd2, 8'h00, 8'h00, 4'd1, 1'b1}; // DEC at 0
    vecs[4]  = '{3'b011, 4'd9, 2'd0, 8'h07, 8'h07, 4'd9, 1'b0}; // JMP
    vecs[5]  = '{3'b100, 4'd1, 2'd1, 8'h00, 8'h00, 4'd2, 1'b0}; // ISZ skip
    vecs[6]  = '{3'b100, 4'd1, 2'd1, 8'h04, 8'h04, 4'd1, 1'b0}; // ISZ no skip
    vecs[7]  = '{3'b101, 4'd3, 2'd3, 8'hAA, 8'h00, 4'd1, 1'b0}; // CLR
    vecs[8]  = '{3'b110, 4'd0, 2'd2, 8'h01, 8'h01, 4'd1, 1'b1}; // reserved
    vecs[9]  = '{3'b000, 4'd0, 2'd3, 8'h3C, 8'h3C, 4'd1, 1'b0}; // NOP
    vecs[10] = '{3'b001, 4'd5, 2'd1, 8'h11, 8'h11, 4'd1, 1'b1}; // INC bad reg
    vecs[11] = '{3'b101, 4'd6, 2'd2, 8'h22, 8'h22, 4'd1, 1'b1}; // CLR bad reg

    fill_halt();

    // Reset state
    #3;
    check("rst_state", 32'(state), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_fault", 32'(fault), 32'd0);
    check("rst_pc", 32'(instr_addr), 32'd0);
    for (int r = 0; r < 4; r++) begin
      read_reg(2'(r), rv);
      check("rst_reg", 32'(rv), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("idle_hold", 32'(state), 32'd0);

    // Program {INC 0, INC 0, HALT} with a clk_en stall in the middle
    mem[0] = ins(3'b001, 4'd0);
    mem[1] = ins(3'b001, 4'd0);
    pulse_start();                // edge 1
    tick(); tick();               // edges 2,3
    clk_en = 1'b0;
    tick(); tick(); tick();
    check("stall_state", 32'(state), 32'd1);
    check("stall_pc", 32'(instr_addr), 32'd1);
    clk_en = 1'b1;
    tick(); tick(); tick();       // edges 4,5,6
    check("p1_not_yet", 32'(halted), 32'd0);
    check("p1_state_e", 32'(state), 32'd2);
    tick();                       // edge 7
    check("p1_halted", 32'(halted), 32'd1);
    check("p1_state", 32'(state), 32'd3);
    check("p1_pc", 32'(instr_addr), 32'd2);
    check("p1_fault", 32'(fault), 32'd0);
    read_reg(2'd0, rv);
    check("p1_reg0", 32'(rv), 32'd2);

    // Countdown loop; debug preload and start in the same HALT cycle
    fill_halt();
    mem[0] = ins(3'b100, 4'd1);
    mem[1] = ins(3'b011, 4'd3);
    mem[2] = ins(3'b111, 4'd0);
    mem[3] = ins(3'b010, 4'd1);
    mem[4] = ins(3'b011, 4'd0);
    dbg_sel = 2'd1; dbg_wdata = 8'd3; dbg_we = 1'b1; start = 1'b1;
    tick();
    dbg_we = 1'b0; start = 1'b0;
    check("cd_state", 32'(state), 32'd1);
    read_reg(2'd1, rv);
    check("cd_preload", 32'(rv), 32'd3);
    run_to_halt("cd_halt", 100);
    read_reg(2'd1, rv);
    check("cd_reg1", 32'(rv), 32'd0);
    check("cd_fault", 32'(fault), 32'd0);
    check("cd_pc", 32'(instr_addr), 32'd2);

    // DEC on zero, reserved opcode, fault is sticky until start
    fill_halt();
    mem[0] = ins(3'b010, 4'd2);
    mem[1] = ins(3'b110, 4'd0);
    pulse_start();
    tick(); tick();
    check("dz_fault", 32'(fault), 32'd1);
    read_reg(2'd2, rv);
    check("dz_reg2", 32'(rv), 32'd0);
    tick(); tick();
    check("rsv_fault", 32'(fault), 32'd1);
    run_to_halt("dz_halt", 20);
    check("dz_sticky", 32'(fault), 32'd1);
    pulse_start();
    check("start_clr_fault", 32'(fault), 32'd0);
    run_to_halt("dz_halt2", 20);

    // Debug writes ignored while running; instr_data only sampled at FETCH
    fill_halt();
    mem[0] = ins(3'b001, 4'd2);
    pulse_start();
    dbg_sel = 2'd3; dbg_wdata = 8'h55; dbg_we = 1'b1;
    tick();                       // FETCH edge
    mem[0] = ins(3'b011, 4'd7);
    tick();                       // EXEC edge
    dbg_we = 1'b0;
    check("late_data_pc", 32'(instr_addr), 32'd1);
    read_reg(2'd3, rv);
    check("dbg_we_ignored", 32'(rv), 32'd0);
    read_reg(2'd2, rv);
    check("latched_inc", 32'(rv), 32'd1);
    mem[0] = ins(3'b111, 4'd0);
    run_to_halt("dbg_halt", 20);

    // JMP 15 then NOP at 15 wraps pc to 0
    fill_halt();
    mem[0]  = ins(3'b011, 4'd15);
    mem[15] = ins(3'b000, 4'd0);
    pulse_start();
    tick(); tick();
    check("jmp15_pc", 32'(instr_addr), 32'd15);
    tick(); tick();
    check("wrap_pc", 32'(instr_addr), 32'd0);
    check("wrap_state", 32'(state), 32'd1);
    mem[0] = ins(3'b111, 4'd0);
    run_to_halt("wrap_halt", 20);

    // ISZ skip from the last word lands on 1
    fill_halt();
    mem[0]  = ins(3'b011, 4'd15);
    mem[15] = ins(3'b100, 4'd3);
    dbg_write(2'd3, 8'd0);
    pulse_start();
    tick(); tick(); tick(); tick();
    check("isz_wrap_pc", 32'(instr_addr), 32'd1);
    run_to_halt("isz_wrap_halt", 20);

    // Single-instruction vector table
    fill_halt();
    for (int v = 0; v < 12; v++) begin
      dbg_write(vecs[v].sel, vecs[v].pre);
      mem[0] = ins(vecs[v].op, vecs[v].arg);
      pulse_start();
      tick(); tick();
      check($sformatf("v%0d_state", v), 32'(state), 32'd1);
      check($sformatf("v%0d_pc", v), 32'(instr_addr), 32'(vecs[v].exp_pc));
      check($sformatf("v%0d_fault", v), 32'(fault), 32'(vecs[v].exp_fault));
      read_reg(vecs[v].sel, rv);
      check($sformatf("v%0d_reg", v), 32'(rv), 32'(vecs[v].exp_reg));
      run_to_halt($sformatf("v%0d_halt", v), 20);
    end

    // Asynchronous reset during EXEC of INC 3
    fill_halt();
    mem[0] = ins(3'b001, 4'd3);
    dbg_write(2'd3, 8'd9);
    pulse_start();
    tick();
    check("ar_in_exec", 32'(state), 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_state", 32'(state), 32'd0);
    read_reg(2'd3, rv);
    check("ar_reg3", 32'(rv), 32'd0);
    check("ar_pc", 32'(instr_addr), 32'd0);
    check("ar_fault", 32'(fault), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("ar_idle", 32'(state), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
